// File: rtl/jpeg_stream_ctrl.sv
// JPEG output stream controller: header ROM replay, Huffman bit packing with
// 0xFF byte stuffing, 1s padding flush and EOI marker, on an AXI-stream byte port.
module jpeg_stream_ctrl #(
   parameter int unsigned HDR_LEN = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_start,
   output logic                        hdr_rd,
   output logic [$clog2(HDR_LEN)-1:0]  hdr_addr,
   input  logic [7:0]                  hdr_data,
   input  logic                        code_valid,
   output logic                        code_ready,
   input  logic [63:0]                 code_bits,
   input  logic [6:0]                  code_size,
   input  logic                        code_last,
   output logic                        byte_valid,
   input  logic                        byte_ready,
   output logic [7:0]                  byte_data,
   output logic                        byte_last,
   output logic                        busy
);

   localparam int unsigned AW    = $clog2(HDR_LEN);
   localparam int unsigned CW    = $clog2(HDR_LEN + 1);
   localparam int unsigned ACC_W = 72;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, EOI0, EOI1} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               stuff_pend;
   logic               last_seen;
   logic               hdr_cap;
   logic [CW-1:0]      hdr_next;

   logic               slot_free;
   logic               code_fire;
   logic [ACC_W-1:0]   code_mask;
   logic [ACC_W-1:0]   code_ins;
   logic [7:0]         top_byte;
   logic [7:0]         pad_byte;

   // Output slot is free when empty or its byte is being taken this cycle
   assign slot_free  = !byte_valid || byte_ready;
   assign code_ready = (state == DATA) && (cnt < CNT_W'(8)) && !stuff_pend && !last_seen;
   assign code_fire  = code_valid && code_ready;
   assign busy       = (state != IDLE);

   // Accumulator is MSB-aligned; bits below the count are kept zero
   assign code_mask = ~({ACC_W{1'b1}} >> code_size);
   assign code_ins  = ({code_bits, 8'h00} & code_mask) >> cnt;
   assign top_byte  = acc[ACC_W-1 -: 8];
   assign pad_byte  = top_byte | (8'hFF >> cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         stuff_pend <= 1'b0;
         last_seen  <= 1'b0;
         hdr_cap    <= 1'b0;
         hdr_next   <= '0;
         hdr_rd     <= 1'b0;
         hdr_addr   <= '0;
         byte_valid <= 1'b0;
         byte_data  <= 8'h00;
         byte_last  <= 1'b0;
      end else begin
         if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
         end
         hdr_rd  <= 1'b0;
         hdr_cap <= hdr_rd;

         case (state)
            IDLE: begin
               if (frame_start) begin
                  state      <= HDR;
                  hdr_next   <= '0;
                  acc        <= '0;
                  cnt        <= '0;
                  stuff_pend <= 1'b0;
                  last_seen  <= 1'b0;
               end
            end

            // One ROM read in flight at a time; the byte lands straight in the output slot
            HDR: begin
               if (!byte_valid && !hdr_rd && !hdr_cap && (hdr_next < CW'(HDR_LEN))) begin
                  hdr_rd   <= 1'b1;
                  hdr_addr <= AW'(hdr_next);
                  hdr_next <= hdr_next + 1'b1;
               end
               if (hdr_cap) begin
                  byte_valid <= 1'b1;
                  byte_data  <= hdr_data;
               end
               if (byte_valid && byte_ready && (hdr_next == CW'(HDR_LEN)))
                  state <= DATA;
            end

            DATA: begin
               if (code_fire) begin
                  acc <= acc | code_ins;
                  cnt <= cnt + CNT_W'(code_size);
                  if (code_last)
                     last_seen <= 1'b1;
               end else if (slot_free && stuff_pend) begin
                  byte_valid <= 1'b1;
                  byte_data  <= 8'h00;
                  stuff_pend <= 1'b0;
               end else if (slot_free && (cnt >= CNT_W'(8))) begin
                  byte_valid <= 1'b1;
                  byte_data  <= top_byte;
                  acc        <= acc << 8;
                  cnt        <= cnt - CNT_W'(8);
                  stuff_pend <= (top_byte == 8'hFF);
               end else if (last_seen && (cnt < CNT_W'(8)) && !stuff_pend) begin
                  state <= FLUSH;
               end
            end

            FLUSH: begin
               if (stuff_pend) begin
                  if (slot_free) begin
                     byte_valid <= 1'b1;
                     byte_data  <= 8'h00;
                     stuff_pend <= 1'b0;
                  end
               end else if (cnt != '0) begin
                  if (slot_free) begin
                     byte_valid <= 1'b1;
                     byte_data  <= pad_byte;
                     acc        <= '0;
                     cnt        <= '0;
                     stuff_pend <= (pad_byte == 8'hFF);
                  end
               end else begin
                  state <= EOI0;
               end
            end

            EOI0: begin
               if (slot_free) begin
                  byte_valid <= 1'b1;
                  byte_data  <= 8'hFF;
                  state      <= EOI1;
               end
            end

            // byte_last marks that D9 already sits in the slot
            EOI1: begin
               if (slot_free) begin
                  if (byte_last) begin
                     state      <= IDLE;
                     acc        <= '0;
                     cnt        <= '0;
                     stuff_pend <= 1'b0;
                     last_seen  <= 1'b0;
                  end else begin
                     byte_valid <= 1'b1;
                     byte_data  <= 8'hD9;
                     byte_last  <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/jpeg_stream_ctrl.md
JPEG_STREAM_CTRL -- requirements
Module: jpeg_stream_ctrl

Interface
REQ-001 Parameter HDR_LEN, default 4, number of header bytes in the external header ROM (SOI through end of SOS), range 2..1024.
REQ-002 Port clk  in  1  single system clock; all logic on the rising edge.
REQ-003 Port rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port frame_start  in  1  one-cycle pulse that starts a frame; accepted only in IDLE.
REQ-005 Port hdr_rd  out  1  header ROM read strobe.
REQ-006 Port hdr_addr  out  $clog2(HDR_LEN)  header ROM byte address.
REQ-007 Port hdr_data  in  8  ROM data, valid exactly one cycle after hdr_rd/hdr_addr.
REQ-008 Port code_valid  in  1  Huffman code word present.
REQ-009 Port code_ready  out  1  code word accepted when code_valid && code_ready.
REQ-010 Port code_bits  in  64  code word, MSB-aligned: meaningful bits are [63 -: code_size].
REQ-011 Port code_size  in  7  code length in bits, 1..64.
REQ-012 Port code_last  in  1  marks the final code word of the frame.
REQ-013 Port byte_valid  out  1  output byte present.
REQ-014 Port byte_ready  in  1  sink accepts byte when byte_valid && byte_ready.
REQ-015 Port byte_data  out  8  JPEG stream byte.
REQ-016 Port byte_last  out  1  high with the final EOI byte (0xD9).
REQ-017 Port busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, HDR, DATA, FLUSH, EOI0, EOI1.
REQ-019 IDLE->HDR on frame_start; in states other than IDLE, frame_start SHALL be ignored.
REQ-020 HDR SHALL read addresses 0..HDR_LEN-1 in order and emit each byte unmodified, with no stuffing; it SHALL hold at most one prefetched byte and never drop or duplicate a byte under backpressure; HDR->DATA after byte HDR_LEN-1 is accepted.
REQ-021 DATA SHALL keep a bit accumulator of at least 71 bits with a count; code_ready = (state==DATA) && count<8 && no stuff byte pending && !last_seen.
REQ-022 An accepted code SHALL be appended MSB-first below the existing bits, and count SHALL increase by code_size.
REQ-023 While count>=8, the block SHALL emit the top 8 bits as one byte and decrement count by 8; sustained throughput SHALL be one byte per cycle when byte_ready=1.
REQ-024 Stuffing: every 0xFF emitted in DATA or FLUSH SHALL be followed immediately by 0x00 before any other byte.
REQ-025 After the code_last word is accepted and count<8 with no pending stuff byte, the FSM SHALL go DATA->FLUSH; if count>0, FLUSH SHALL pad the remaining bits with 1s to 8 bits and emit that byte, stuffed per REQ-024; if count==0, it SHALL emit nothing; then FLUSH->EOI0.
REQ-026 EOI0 SHALL emit 0xFF, then EOI1 SHALL emit 0xD9 with byte_last=1, neither stuffed; after acceptance EOI1->IDLE and the accumulator SHALL be cleared.
REQ-027 AXI-stream rule: while byte_valid && !byte_ready, byte_data, byte_last and byte_valid SHALL be held stable.
REQ-028 A code_valid with code_size=0 or >64 is illegal; behaviour is unspecified, but the FSM SHALL still return to IDLE via code_last.

Reset
REQ-029 While rst_n=0, all of the following SHALL be forced immediately: state=IDLE; byte_valid, byte_last, byte_data, code_ready, hdr_rd and hdr_addr = 0; busy=0; accumulator count=0; pending stuff flag cleared.
REQ-030 Reset mid-frame SHALL discard all partial state; the next frame_start SHALL produce a complete frame starting at header address 0.

Verification
REQ-031 HDR_LEN=4, ROM={FF,D8,FF,DB}, one code 0xA5 (size 8, last) -> bytes FF D8 FF DB A5 FF D9, with byte_last only on D9.
REQ-032 Codes 0xFF (size 8), then 3'b101 (size 3, last) -> after the header: FF 00 BF FF D9.
REQ-033 Code 4'b1111 (size 4, last) -> after the header: FF 00 FF D9 (the padded 0xFF is stuffed; EOI is not).
REQ-034 Code 3'b010 (size 3), then 64 zeros (size 64, last) -> after the header: 40, seven 00 bytes, 1F, FF, D9; code_ready is low while count>=8.
REQ-035 Scenario REQ-032 with byte_ready toggling every cycle -> identical byte sequence, outputs stable during stalls, no loss or duplication.
REQ-036 rst_n pulsed low during DATA, then frame_start -> busy=0 during reset, then a full frame from FF D8 with no residual bits.
